// File: rtl/cdb_complete_buffer_pkg.sv
// cdb_complete_buffer_pkg: shared entry/slot types and branch-mask helpers for the completion stage
package cdb_complete_buffer_pkg;
    localparam int CDB_PREG_W  = 6;
    localparam int CDB_DATA_W  = 32;
    localparam int CDB_BMASK_W = 4;

    typedef struct packed {
        logic                   valid;
        logic [CDB_PREG_W-1:0]  preg;
        logic [CDB_DATA_W-1:0]  data;
        logic [CDB_BMASK_W-1:0] bmask;
    } cdb_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [CDB_PREG_W-1:0] preg;
        logic [CDB_DATA_W-1:0] data;
    } cdb_slot_t;

    function automatic logic squashed(input cdb_entry_t e, input logic [CDB_BMASK_W-1:0] resolve,
                                      input logic mispred);
        return mispred && |(e.bmask & resolve);
    endfunction

    // Clearing the bit is harmless on a mispredict: surviving entries never had it set.
    function automatic cdb_entry_t bmask_clear(input cdb_entry_t e, input logic [CDB_BMASK_W-1:0] resolve,
                                               input logic mispred);
        cdb_entry_t r;
        r = e;
        r.valid = e.valid && !squashed(e, resolve, mispred);
        r.bmask = e.bmask & ~resolve;
        return r;
    endfunction
endpackage

// File: rtl/cdb_complete_buffer_queue.sv
// fu_result_queue: per-FU circular result queue with in-place branch resolve/squash and free pop of dead heads
module fu_result_queue
    import cdb_complete_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  cdb_entry_t             push_entry,
    input  logic                   pop,
    input  logic [CDB_BMASK_W-1:0] resolve,
    input  logic                   mispred,
    output cdb_slot_t              head,
    output logic [CW-1:0]          count
);
    cdb_entry_t    mem [DEPTH];
    cdb_entry_t    in_e;
    logic [PW-1:0] hd, tl;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head    = '{valid: count != '0 && mem[hd].valid && !squashed(mem[hd], resolve, mispred),
                    preg: mem[hd].preg, data: mem[hd].data};
        in_e    = bmask_clear(push_entry, resolve, mispred);
        do_push = push && in_e.valid && count < CW'(DEPTH);
        do_pop  = count != '0 && (pop || !head.valid);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hd    <= '0;
            tl    <= '0;
            count <= '0;
            mem   <= '{default: '0};
        end else begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= bmask_clear(mem[i], resolve, mispred);
            if (do_push) begin
                mem[tl] <= in_e;
                tl      <= nxt(tl);
            end
            if (do_pop)
                hd <= nxt(hd);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/cdb_complete_buffer.sv
// cdb_complete_buffer: per-FU result queues feeding an N-wide registered CDB through a rotating-priority arbiter
module cdb_complete_buffer
    import cdb_complete_buffer_pkg::*;
#(
    parameter int N       = 2,
    parameter int NUM_FU  = 6,
    parameter int DEPTH   = 2,
    parameter int PREG_W  = CDB_PREG_W,
    parameter int DATA_W  = CDB_DATA_W,
    parameter int BMASK_W = CDB_BMASK_W,
    localparam int OW = $clog2(NUM_FU * DEPTH + 1),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int RW = NUM_FU > 1 ? $clog2(NUM_FU) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_FU-1:0]           fu_valid,
    input  logic [NUM_FU*PREG_W-1:0]    fu_preg,
    input  logic [NUM_FU*DATA_W-1:0]    fu_data,
    input  logic [NUM_FU*BMASK_W-1:0]   fu_bmask,
    output logic [NUM_FU-1:0]           fu_ready,
    input  logic [BMASK_W-1:0]          b_mm_resolve,
    input  logic                        b_mm_mispred,
    output logic [N-1:0]                cdb_valid,
    output logic [N*PREG_W-1:0]         cdb_preg,
    output logic [N*DATA_W-1:0]         cdb_data,
    output logic [OW-1:0]               occupancy
);
    cdb_slot_t         head   [NUM_FU];
    logic [CW-1:0]     cnt    [NUM_FU];
    cdb_slot_t         slot_n [N];
    cdb_slot_t         slot_q [N];
    logic [NUM_FU-1:0] grant;
    logic [RW-1:0]     rr_ptr, rr_nxt;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
        cdb_entry_t in_e;
        assign in_e = '{valid: 1'b1, preg: fu_preg[g*PREG_W +: PREG_W], data: fu_data[g*DATA_W +: DATA_W],
                        bmask: fu_bmask[g*BMASK_W +: BMASK_W]};
        assign fu_ready[g] = cnt[g] < CW'(DEPTH);
        fu_result_queue #(.DEPTH(DEPTH)) u_q (
            .clock(clock), .reset(reset), .push(fu_valid[g] & fu_ready[g]), .push_entry(in_e),
            .pop(grant[g]), .resolve(b_mm_resolve), .mispred(b_mm_mispred), .head(head[g]), .count(cnt[g])
        );
    end

    always_comb begin
        int ng, idx, last;
        grant  = '0;
        slot_n = '{default: '0};
        ng     = 0;
        idx    = 0;
        last   = 0;
        for (int j = 0; j < NUM_FU; j++) begin
            idx = int'(rr_ptr) + j;
            idx = idx >= NUM_FU ? idx - NUM_FU : idx;
            if (ng < N && head[idx].valid) begin
                grant[idx] = 1'b1;
                slot_n[ng] = head[idx];
                last       = idx;
                ng++;
            end
        end
        rr_nxt = ng == 0 ? rr_ptr : RW'(last == NUM_FU - 1 ? 0 : last + 1);
    end

    // Occupancy counts squashed entries that have not yet popped.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < NUM_FU; i++)
            occupancy = occupancy + OW'(cnt[i]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
            slot_q <= '{default: '0};
        end else begin
            rr_ptr <= rr_nxt;
            slot_q <= slot_n;
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_slot
        assign cdb_valid[k]                = slot_q[k].valid;
        assign cdb_preg[k*PREG_W +: PREG_W] = slot_q[k].preg;
        assign cdb_data[k*DATA_W +: DATA_W] = slot_q[k].data;
    end
endmodule

// File: doc/cdb_complete_buffer.md
Name: cdb_complete_buffer

Overview:
- Parametrised completion stage between the execute FUs and the N-wide CDB.
- Each FU gets a DEPTH-entry result queue with valid/ready backpressure. Completed results are no longer dropped when the CDB is busy.
- A rotating-priority arbiter drives up to N registered CDB slots per cycle.
- Stored and incoming results are cleaned on branch resolve and squashed on branch mispredict.

Parameters:
- N, 2, CDB width (results broadcast per cycle).
- NUM_FU, 6, number of FU result producers.
- DEPTH, 2, entries per FU queue (>=1).
- PREG_W, 6, physical register tag width.
- DATA_W, 32, result data width.
- BMASK_W, 4, branch mask width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- fu_valid  in  NUM_FU  FU i presents a result this cycle.
- fu_preg  in  NUM_FU*PREG_W  destination tag per FU.
- fu_data  in  NUM_FU*DATA_W  result value per FU.
- fu_bmask  in  NUM_FU*BMASK_W  branch dependence mask per FU.
- fu_ready  out  NUM_FU  FU i queue can accept this cycle.
- b_mm_resolve  in  BMASK_W  one-hot branch being resolved; zero means none.
- b_mm_mispred  in  1  resolving branch mispredicted.
- cdb_valid  out  N  CDB slot valid.
- cdb_preg  out  N*PREG_W  completing tag per slot.
- cdb_data  out  N*DATA_W  completing value per slot.
- occupancy  out  clog2(NUM_FU*DEPTH+1)  total live entries, registered.

Behaviour:
- Reset:
  - All queue counts, heads and tails = 0; rr_ptr = 0.
  - cdb_valid/preg/data = 0; occupancy = 0; fu_ready = all 1s.
- Reset mid-operation discards all entries. CDB outputs are 0 the cycle after reset is sampled.
- Enqueue:
  - An entry is accepted on fu_valid[i] & fu_ready[i].
  - fu_ready[i] = (count[i] < DEPTH), from current count only; there is no same-cycle pop-through.
  - fu_valid while not ready is ignored: the entry is lost and no state changes.
- Queues are circular. head/tail wrap DEPTH-1 -> 0. count stays within 0..DEPTH.
- Branch handling is combinational, applied before arbitration in the same cycle:
  - Resolve correct (resolve != 0, mispred = 0): clear the resolve bit in every stored bmask and in the incoming bmask before it is written.
  - Mispredict (resolve != 0, mispred = 1): clear valid on every stored entry with (bmask & resolve) != 0. Drop an incoming entry with that bit set (the handshake still completes; nothing is written).
- Squashed entries at a queue head pop the same cycle without consuming a CDB slot. One free pop per FU per cycle.
- Arbitration:
  - Scan FUs from rr_ptr upward, modulo NUM_FU. Grant the first N FUs whose head entry is valid after branch handling.
  - One grant per FU per cycle. Slot k receives the k-th grant; unused slots have valid = 0.
  - rr_ptr <= (last granted index + 1) mod NUM_FU; it is unchanged if there are no grants.
- Latency:
  - An entry enqueued at edge t is eligible in cycle t..t+1 and appears on the CDB registers at edge t+1 at the earliest.
  - An entry arriving while its FU queue is empty reaches the CDB in 1 cycle.
- Pops and pushes to the same queue in one cycle: count unchanged, both pointers advance.
- CDB outputs are registered and visible for exactly one cycle. A mispredict does not retract already-registered CDB slots.
- occupancy = registered sum of counts, including not-yet-popped squashed entries.

Decomposition:
- Shared package:
  - cdb_entry_t {valid, preg[PREG_W], data[DATA_W], bmask[BMASK_W]}.
  - cdb_slot_t {valid, preg, data}.
  - Function bmask_clear(entry, resolve, mispred).
- Sub-module fu_result_queue (one instance per FU, DEPTH param):
  - Ports: push, push entry, pop, head entry, count.
  - Performs the resolve/squash update internally.
- Arbiter and output registers live in the top.

Test Plan:
- Single result, idle: FU2 valid preg=5 data=0xAA bmask=0 at edge 0 -> cdb_valid=2'b01, cdb_preg[0]=5, data 0xAA after edge 1; occupancy back to 0 after edge 1.
- Contention, N=2, all 6 FUs valid one cycle, rr_ptr=0:
  - Cycle 1: FUs 0,1 broadcast. Cycle 2: FUs 2,3. Cycle 3: FUs 4,5.
  - rr_ptr = 2, 4, 0 after each cycle. No loss.
- Backpressure, DEPTH=2: FU0 valid 4 consecutive cycles while FUs 1-5 saturate the grants from rr_ptr=1.
  - fu_ready[0] drops to 0 once count=2; held entries drain in order.
  - The 3rd and 4th pushes are ignored while ready=0.
- Mispredict: FU3 queue holds {preg7, bmask 0010} (head) and {preg8, bmask 0000}; resolve=0010, mispred=1.
  - preg7 is never broadcast and pops free.
  - preg8 broadcasts the next cycle.
  - An incoming FU4 entry with bmask 0010 in the same cycle is dropped.
- Correct resolve: stored bmask 0110, resolve=0100, mispred=0 -> bmask becomes 0010. A later mispred on 0100 does not kill the entry.
- Reset mid-stream with 5 live entries -> occupancy=0, cdb_valid=0, fu_ready all 1 the next cycle; none of the 5 entries ever appears.
